// File: rtl/trng_bit_packer.sv
// Packs serial entropy bits MSB-first into WIDTH-bit words, health-checks them, and queues whole words.
// Latency: a word is at the FIFO head (valid_o) right after the edge that samples its last bit.
// Backpressure: none upstream; a word completed into a full FIFO with no pop is dropped and overflow_o is set.
//
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   en_i          - packer enable; low discards the partial word and the run history
//   bit_valid_i   - raw bit strobe; bit_i is sampled when bit_valid_i & en_i
//   clr_i         - clears fail_o / overflow_o and the packer state; FIFO contents are kept
//   rd_i          - pop request, ignored while the FIFO is empty
//   word_o        - FIFO head word (fall-through), meaningful while valid_o = 1
//   valid_o       - FIFO not empty
//   level_o       - number of words held, 0..DEPTH
//   fail_o        - sticky repetition-count failure
//   overflow_o    - sticky: a completed word was dropped on a full FIFO
module trng_bit_packer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned REP_LIMIT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic                       bit_valid_i,
  input  logic                       bit_i,
  input  logic                       clr_i,
  input  logic                       rd_i,
  output logic [WIDTH-1:0]           word_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       fail_o,
  output logic                       overflow_o
);

  localparam int unsigned CW = $clog2(WIDTH);       // bit counter, 0..WIDTH-1
  localparam int unsigned AW = $clog2(DEPTH);       // FIFO pointer
  localparam int unsigned LW = $clog2(DEPTH + 1);   // FIFO level, 0..DEPTH
  localparam int unsigned RW = $clog2(REP_LIMIT + 1);

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [RW-1:0] REP_MAX  = RW'(REP_LIMIT);

  // Packer state. Only WIDTH-1 bits of history are needed: the incoming bit
  // completes the word, so the register never has to hold a full word.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  // Run length of the current run of identical bits; 0 means "no history",
  // so the next accepted bit always starts a fresh run.
  logic [RW-1:0]    run_cnt_q, run_cnt_d;

  // Flags
  logic fail_q, fail_d;
  logic ovf_q, ovf_d;

  // FIFO state
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             valid_q, valid_d;

  // Per-cycle events
  logic [WIDTH-1:0] word_in;
  logic             accept;
  logic             same_run;
  logic [RW-1:0]    run_next;
  logic             fail_evt;
  logic             word_done;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             full;
  logic             drop;

  always_comb begin
    // The word that the current bit would complete.
    word_in   = {shift_q, bit_i};

    // clr_i takes the cycle: a bit presented alongside it is not accepted.
    accept    = en_i & bit_valid_i & ~fail_q & ~clr_i;

    // While a run is live, shift_q[0] is always the previously accepted bit.
    same_run  = (run_cnt_q != '0) && (bit_i == shift_q[0]);
    run_next  = same_run ? (run_cnt_q + RW'(1)) : RW'(1);

    fail_evt  = accept && (run_next == REP_MAX);
    word_done = accept && (bit_cnt_q == LAST_BIT);

    pop       = rd_i && (level_q != '0);
    full      = (level_q == FULL_LVL);

    // The word finished by a failing bit is never stored.
    push_req  = word_done && !fail_evt;
    // A pop on the same edge frees the slot, so a full FIFO can still take it.
    push      = push_req && (!full || pop);
    drop      = push_req && full && !pop;
  end

  // Packer and flag next-state.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    run_cnt_d = run_cnt_q;
    fail_d    = fail_q;
    ovf_d     = ovf_q;

    if (clr_i) begin
      fail_d    = 1'b0;
      ovf_d     = 1'b0;
      shift_d   = '0;
      bit_cnt_d = '0;
      run_cnt_d = '0;
    end else if (fail_evt) begin
      fail_d    = 1'b1;
      shift_d   = '0;
      bit_cnt_d = '0;
      run_cnt_d = '0;
    end else begin
      if (!en_i) begin
        shift_d   = '0;
        bit_cnt_d = '0;
        run_cnt_d = '0;
      end else if (accept) begin
        shift_d   = word_in[WIDTH-2:0];
        bit_cnt_d = word_done ? '0 : (bit_cnt_q + CW'(1));
        run_cnt_d = run_next;
      end
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  // FIFO pointer / level next-state. Pushes never coincide with clr_i or a
  // failure, so only the failure flush needs to override the normal path;
  // a pop under clr_i goes through the normal path and is honoured.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (fail_evt) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        level_d = level_q + LW'(1);
      end else if (pop && !push) begin
        level_d = level_q - LW'(1);
      end
    end

    valid_d = (level_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      run_cnt_q <= '0;
      fail_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      run_cnt_q <= run_cnt_d;
      fail_q    <= fail_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
    end
  end

  // Storage is cleared on reset so word_o reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= word_in;
    end
  end

  assign word_o     = mem_q[rd_ptr_q];
  assign valid_o    = valid_q;
  assign level_o    = level_q;
  assign fail_o     = fail_q;
  assign overflow_o = ovf_q;

endmodule
